interval_timer: RTL and testbench

INTERVAL_TIMER -- requirements
Module: interval_timer

---
 rtl/interval_timer.sv | 74 +++++++
 tb/tb_interval_timer.sv | 132 +++++++++++++
 2 files changed

// File: rtl/interval_timer.sv
// interval_timer: programmable tick-prescaled countdown timer with BASE/EXT/YEL interval registers
module interval_timer #(
  parameter int         CLK_DIV      = 4,
  parameter logic [3:0] BASE_DEFAULT = 4'd6,
  parameter logic [3:0] EXT_DEFAULT  = 4'd3,
  parameter logic [3:0] YEL_DEFAULT  = 4'd2
) (
  input  logic       clk,
  input  logic       sys_reset_n,
  input  logic       start_timer,
  input  logic [1:0] interval_address,
  input  logic       prg_sync_in,
  input  logic [1:0] time_parameter_selector,
  input  logic [3:0] time_value,
  output logic       expired,
  output logic [3:0] time_left
);
  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0] state_q, state_d;
  logic [3:0] base_q, base_d, ext_q, ext_d, yel_q, yel_d;
  logic [3:0] tl_q, tl_d, sel_val;
  logic [PW-1:0] presc_q, presc_d;
  logic exp_q, exp_d, tick;
  // loads read the _q registers, so a same-edge write is seen only by the next load
  assign sel_val = interval_address == 2'b01 ? ext_q : interval_address == 2'b10 ? yel_q : base_q;
  assign tick = state_q == RUN && presc_q == LAST;
  always_comb begin
    base_d = prg_sync_in && time_parameter_selector == 2'b00 ? (time_value == 4'd0 ? BASE_DEFAULT : time_value) : base_q;
    ext_d  = prg_sync_in && time_parameter_selector == 2'b01 ? (time_value == 4'd0 ? EXT_DEFAULT : time_value) : ext_q;
    yel_d  = prg_sync_in && time_parameter_selector == 2'b10 ? (time_value == 4'd0 ? YEL_DEFAULT : time_value) : yel_q;
    state_d = state_q;
    tl_d = tl_q;
    presc_d = presc_q;
    exp_d = exp_q;
    if (start_timer) begin
      state_d = RUN;
      tl_d = sel_val;
      presc_d = '0;
      exp_d = 1'b0;
    end else if (state_q == RUN) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        tl_d = tl_q > 4'd1 ? tl_q - 4'd1 : 4'd0;
        exp_d = tl_q <= 4'd1;
        state_d = tl_q <= 4'd1 ? DONE : RUN;
      end
    end
  end
  always_ff @(posedge clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_q <= IDLE;
      base_q <= BASE_DEFAULT;
      ext_q <= EXT_DEFAULT;
      yel_q <= YEL_DEFAULT;
      tl_q <= 4'd0;
      presc_q <= '0;
      exp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      ext_q <= ext_d;
      yel_q <= yel_d;
      tl_q <= tl_d;
      presc_q <= presc_d;
      exp_q <= exp_d;
    end
  end
  assign expired = exp_q;
  assign time_left = tl_q;
endmodule

// File: tb/tb_interval_timer.sv
// tb_interval_timer: directed stimulus with a scoreboard of expected expiry cycles checked by a monitor
module tb_interval_timer;
  logic clk = 1'b0;
  logic sys_reset_n = 1'b0;
  logic start_timer = 1'b0;
  logic [1:0] interval_address = 2'b00;
  logic prg_sync_in = 1'b0;
  logic [1:0] time_parameter_selector = 2'b00;
  logic [3:0] time_value = 4'd0;
  logic expired;
  logic [3:0] time_left;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int sb[$];
  logic exp_prev = 1'b0;

  interval_timer #(.CLK_DIV(4)) dut (
    .clk(clk),
    .sys_reset_n(sys_reset_n),
    .start_timer(start_timer),
    .interval_address(interval_address),
    .prg_sync_in(prg_sync_in),
    .time_parameter_selector(time_parameter_selector),
    .time_value(time_value),
    .expired(expired),
    .time_left(time_left)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string n, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, req, cyc);
    end
  endfunction

  // monitor: every rising edge of expired must match the oldest expected expiry
  always @(negedge clk) begin
    if (sys_reset_n && expired && !exp_prev) begin
      if (sb.size() == 0) check("unexpected_expire", cyc, -1);
      else begin
        check("expire_cycle", cyc, sb.pop_front());
        check("time_left_at_expire", int'(time_left), 0);
      end
    end
    exp_prev <= expired;
  end

  // one drive cycle; dur >= 0 schedules an expiry dur cycles after this edge
  task automatic step(input bit st, input logic [1:0] a, input bit pr, input logic [1:0] s,
                      input logic [3:0] v, input int dur);
    @(negedge clk);
    if (dur >= 0) sb.push_back(cyc + 1 + dur);
    start_timer = st;
    interval_address = a;
    prg_sync_in = pr;
    time_parameter_selector = s;
    time_value = v;
    @(negedge clk);
    start_timer = 1'b0;
    prg_sync_in = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    if (sb.size() != 0) begin
      check("expire_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  initial begin
    #2;
    check("reset_expired", int'(expired), 0);
    check("reset_time_left", int'(time_left), 0);
    @(negedge clk);
    @(negedge clk);
    sys_reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_expired", int'(expired), 0);
    check("idle_time_left", int'(time_left), 0);
    step(1'b1, 2'b00, 1'b0, 2'b00, 4'd0, 24);
    check("base_load", int'(time_left), 6);
    step(1'b0, 2'b00, 1'b1, 2'b00, 4'd2, -1);
    wait_done();
    check("done_expired", int'(expired), 1);
    step(1'b0, 2'b00, 1'b1, 2'b00, 4'd0, -1);
    step(1'b0, 2'b00, 1'b1, 2'b01, 4'd5, -1);
    step(1'b1, 2'b01, 1'b0, 2'b00, 4'd0, 20);
    check("ext_load", int'(time_left), 5);
    wait_done();
    step(1'b0, 2'b00, 1'b1, 2'b01, 4'd0, -1);
    step(1'b1, 2'b01, 1'b0, 2'b00, 4'd0, 12);
    wait_done();
    step(1'b1, 2'b10, 1'b0, 2'b00, 4'd0, -1);
    repeat (4) @(negedge clk);
    step(1'b1, 2'b00, 1'b0, 2'b00, 4'd0, 24);
    wait_done();
    check("pre_reload_expired", int'(expired), 1);
    step(1'b1, 2'b10, 1'b0, 2'b00, 4'd0, 8);
    check("reload_drops_expired", int'(expired), 0);
    wait_done();
    step(1'b1, 2'b00, 1'b1, 2'b00, 4'd9, 24);
    wait_done();
    step(1'b1, 2'b00, 1'b0, 2'b00, 4'd0, 36);
    wait_done();
    step(1'b1, 2'b00, 1'b0, 2'b00, 4'd0, -1);
    check("mid_count_time_left", int'(time_left), 9);
    #2 sys_reset_n = 1'b0;
    #1;
    check("async_reset_expired", int'(expired), 0);
    check("async_reset_time_left", int'(time_left), 0);
    @(negedge clk);
    @(negedge clk);
    sys_reset_n = 1'b1;
    step(1'b0, 2'b00, 1'b1, 2'b11, 4'd1, -1);
    step(1'b1, 2'b00, 1'b0, 2'b00, 4'd0, 24);
    check("base_after_reset", int'(time_left), 6);
    wait_done();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
